reg_file_8x8: RTL and testbench

Eight-entry register file that consumes the one-hot word produced by the 3-to-8 decoder as its write-enable bus. It forms the write-back and storage stage of the MIPS datapath slice. It provides two synchronous read ports, MIPS-style hardwired-zero register 0, one-hot legality checking, and a write counter for debug. It sits directly downstream of the 3-to-8 decoder.

---
 rtl/reg_file_8x8.sv | 95 +++++++++
 tb/tb_reg_file_8x8.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x8.sv
// reg_file_8x8: eight-entry register file with hardwired-zero register 0,
// two registered read ports, sticky illegal-enable flag and write counter.
// Optional build macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
module reg_file_8x8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       we_onehot,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       ra1,
  input  logic [2:0]       ra2,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             wr_err,
  output logic [7:0]       wr_cnt
);

  logic [WIDTH-1:0] r_mem [8];
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic             r_err;
  logic [7:0]       r_cnt;

  logic             w_any;
  logic             w_single;
  logic             w_illegal;
  logic             w_accept;
  logic [2:0]       w_idx;
  logic [WIDTH-1:0] w_rd1_next;
  logic [WIDTH-1:0] w_rd2_next;

  // Classify the enable word: idle, single legal write, or illegal multi-hot.
  always_comb begin
    w_any     = (we_onehot != '0);
    w_single  = w_any && ((we_onehot & (we_onehot - 8'd1)) == '0);
    w_illegal = w_any && !w_single;
    w_idx     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (we_onehot[i]) begin
        w_idx = 3'(i);
      end
    end
    // Writes to register 0 are legal but discarded, so they are not accepted.
    w_accept  = w_single && (w_idx != 3'd0);
  end

  // Next read data; register 0 always reads zero.
  always_comb begin
    w_rd1_next = (ra1 == 3'd0) ? '0 : r_mem[ra1];
    w_rd2_next = (ra2 == 3'd0) ? '0 : r_mem[ra2];
`ifdef REG_FILE_BYPASS_EN
    // Forward only accepted writes, so reg 0 and illegal enables never bypass.
    if (w_accept && (w_idx == ra1)) begin
      w_rd1_next = wdata;
    end
    if (w_accept && (w_idx == ra2)) begin
      w_rd2_next = wdata;
    end
`endif
  end

  // Storage, read registers, sticky error and write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_mem[i] <= '0;
      end
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mem[w_idx] <= wdata;
        r_cnt        <= r_cnt + 8'd1;
      end
      r_rd1 <= w_rd1_next;
      r_rd2 <= w_rd2_next;
      // Set has priority over clear when both occur in one cycle.
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign rd1    = r_rd1;
  assign rd2    = r_rd2;
  assign wr_err = r_err;
  assign wr_cnt = r_cnt;

endmodule

// File: tb/tb_reg_file_8x8.sv
// tb_reg_file_8x8: directed scoreboard bench for reg_file_8x8.
// Honours REG_FILE_BYPASS_EN for read-during-write expectations.
module tb_reg_file_8x8;

  logic       clk;
  logic       rst_n;
  logic [7:0] we_onehot;
  logic [7:0] wdata;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic       clr_err;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic       wr_err;
  logic [7:0] wr_cnt;

  typedef struct {
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_mem [8];
  logic       m_err;
  logic [7:0] m_cnt;
  int         n_checks;
  int         n_errors;
  int         wraps_seen;
  logic [7:0] prev_cnt;

  reg_file_8x8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_onehot(we_onehot),
    .wdata    (wdata),
    .ra1      (ra1),
    .ra2      (ra2),
    .clr_err  (clr_err),
    .rd1      (rd1),
    .rd2      (rd2),
    .wr_err   (wr_err),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_err = 1'b0;
    m_cnt = 8'h00;
    sb.delete();
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a, input logic fwd,
                                            input int idx, input logic [7:0] wd);
    if (a == 3'd0) return 8'h00;
    if (fwd && idx == int'(a)) return wd;
    return m_mem[a];
  endfunction

  // One clock cycle: predict, push, clock, pop and compare.
  task automatic cycle(input logic [7:0] we, input logic [7:0] wd,
                       input logic [2:0] a1, input logic [2:0] a2, input logic clr);
    exp_t e;
    exp_t g;
    int   ones;
    int   idx;
    logic fwd;
    ones = $countones(we);
    idx  = 0;
    for (int i = 0; i < 8; i++) if (we[i]) idx = i;
    fwd = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    fwd = (ones == 1) && (idx != 0);
`endif
    e.rd1 = model_read(a1, fwd, idx, wd);
    e.rd2 = model_read(a2, fwd, idx, wd);
    if (ones == 1 && idx != 0) begin
      m_mem[idx] = wd;
      m_cnt      = m_cnt + 8'd1;
    end
    if (ones > 1) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    e.err = m_err;
    e.cnt = m_cnt;
    sb.push_back(e);

    we_onehot = we;
    wdata     = wd;
    ra1       = a1;
    ra2       = a2;
    clr_err   = clr;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("rd1", 32'(rd1), 32'(g.rd1));
      chk("rd2", 32'(rd2), 32'(g.rd2));
      chk("wr_err", 32'(wr_err), 32'(g.err));
      chk("wr_cnt", 32'(wr_cnt), 32'(g.cnt));
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    wraps_seen = 0;
    rst_n      = 1'b0;
    we_onehot  = '0;
    wdata      = '0;
    ra1        = '0;
    ra2        = '0;
    clr_err    = 1'b0;
    model_reset();

    #12;
    chk("reset_rd1", 32'(rd1), 32'h0);
    chk("reset_rd2", 32'(rd2), 32'h0);
    chk("reset_err", 32'(wr_err), 32'h0);
    chk("reset_cnt", 32'(wr_cnt), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write registers 1..7, then read them back on both ports.
    for (int i = 1; i < 8; i++) cycle(8'(1 << i), 8'(8'h11 * i), 3'd0, 3'd0, 1'b0);
    for (int i = 1; i < 8; i++) cycle(8'h00, 8'h00, 3'(i), 3'(8 - i), 1'b0);
    chk("cnt_after_7", 32'(wr_cnt), 32'd7);
    cycle(8'h00, 8'h00, 3'd3, 3'd3, 1'b0);
    chk("reg3_const", 32'(rd1), 32'h33);

    // Register 0 write is discarded and not counted.
    cycle(8'h01, 8'hFF, 3'd0, 3'd0, 1'b0);
    cycle(8'h00, 8'h00, 3'd0, 3'd1, 1'b0);
    chk("reg0_zero", 32'(rd1), 32'h00);
    chk("reg0_cnt", 32'(wr_cnt), 32'd7);

    // Illegal multi-hot enable.
    cycle(8'h14, 8'h5A, 3'd2, 3'd4, 1'b0);
    chk("illegal_err", 32'(wr_err), 32'd1);
    cycle(8'h00, 8'h00, 3'd2, 3'd4, 1'b0);
    chk("illegal_reg2", 32'(rd1), 32'h22);
    chk("illegal_reg4", 32'(rd2), 32'h44);
    cycle(8'h00, 8'h00, 3'd0, 3'd0, 1'b1);
    chk("clr_err", 32'(wr_err), 32'd0);
    cycle(8'h81, 8'h99, 3'd0, 3'd7, 1'b1);
    chk("set_wins", 32'(wr_err), 32'd1);
    cycle(8'h18, 8'hEE, 3'd4, 3'd3, 1'b0);
    cycle(8'h00, 8'h00, 3'd0, 3'd0, 1'b1);

    // Read during write on register 5.
    cycle(8'h20, 8'h01, 3'd0, 3'd0, 1'b0);
    cycle(8'h20, 8'h3C, 3'd5, 3'd5, 1'b0);
`ifdef REG_FILE_BYPASS_EN
    chk("rdw_same", 32'(rd1), 32'h3C);
`else
    chk("rdw_same", 32'(rd1), 32'h01);
`endif
    cycle(8'h00, 8'h00, 3'd5, 3'd0, 1'b0);
    chk("rdw_next", 32'(rd1), 32'h3C);

    // 256 accepted writes wrap the counter back to its start value.
    prev_cnt = wr_cnt;
    for (int k = 0; k < 256; k++) begin
      cycle(8'(1 << (1 + k % 7)), 8'(k), 3'(k % 8), 3'((k + 3) % 8), 1'b0);
      if (prev_cnt == 8'hFF && wr_cnt == 8'h00) wraps_seen++;
      prev_cnt = wr_cnt;
    end
    chk("wrap_seen", 32'(wraps_seen), 32'd1);
    chk("wrap_err", 32'(wr_err), 32'd0);

    // Asynchronous reset in the middle of a write.
    cycle(8'h08, 8'hAA, 3'd0, 3'd0, 1'b0);
    cycle(8'h03, 8'h12, 3'd3, 3'd3, 1'b0);
    we_onehot = 8'h08;
    wdata     = 8'h55;
    ra1       = 3'd3;
    ra2       = 3'd3;
    #2 rst_n  = 1'b0;
    #1;
    chk("async_rd1", 32'(rd1), 32'h0);
    chk("async_rd2", 32'(rd2), 32'h0);
    chk("async_err", 32'(wr_err), 32'h0);
    chk("async_cnt", 32'(wr_cnt), 32'h0);
    @(posedge clk);
    #1;
    chk("hold_rd1", 32'(rd1), 32'h0);
    chk("hold_cnt", 32'(wr_cnt), 32'h0);
    we_onehot = 8'h00;
    rst_n     = 1'b1;
    model_reset();
    cycle(8'h00, 8'h00, 3'd3, 3'd3, 1'b0);
    chk("post_reset_reg3", 32'(rd1), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
